// File: rtl/gin_id_scan_loader.sv
// ---------------------------------------------------------------------------
// gin_id_scan_loader
//
// Loads one column tag ID per multicast controller (MCC) into the GIN X-bus
// daisy-chained ID scan path (se_id / si_id / so_id). An optional second
// pass shifts the same pattern through again while checking what comes back
// on so_id. gin_hold stays high for the whole sequence so that the GIN source
// keeps enable_in low until the IDs are valid.
//
// Ports
//   link_clk   in   clock shared with the scan chain
//   reset      in   asynchronous, active-low reset
//   start      in   load request, sampled only in IDLE
//   verify_en  in   sampled with start; 1 = run the readback pass
//   abort      in   return to IDLE from any state (highest priority)
//   cfg_ids    in   flat ID vector, column c at [c*COL_TAG_WIDTH +: COL_TAG_WIDTH]
//   so_id      in   scan-out of the last MCC in the chain
//   se_id      out  scan enable to every MCC
//   si_id      out  scan-in to the first MCC
//   gin_hold   out  high while busy
//   busy       out  sequence in progress
//   done       out  one-cycle pulse at sequence end
//   error      out  sticky readback mismatch flag
//   err_cnt    out  mismatching bits in the last verify pass (saturating)
// ---------------------------------------------------------------------------
module gin_id_scan_loader #(
    parameter  int NUM_OF_COLS   = 14,
    parameter  int COL_TAG_WIDTH = 4,
    localparam int CHAIN_LEN     = NUM_OF_COLS * COL_TAG_WIDTH,
    localparam int CNT_W         = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 link_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 verify_en,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] cfg_ids,
    input  logic                 so_id,
    output logic                 se_id,
    output logic                 si_id,
    output logic                 gin_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_W-1:0]     err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(CHAIN_LEN);

    state_t               r_state,   r_state_next;
    logic [CHAIN_LEN-1:0] r_shift,   r_shift_next;
    logic [CNT_W-1:0]     r_bit_cnt, r_bit_cnt_next;
    logic                 r_verify,  r_verify_next;
    logic                 r_se,      r_se_next;
    logic                 r_si,      r_si_next;
    logic                 r_busy,    r_busy_next;
    logic                 r_done,    r_done_next;
    logic                 r_error,   r_error_next;
    logic [CNT_W-1:0]     r_err_cnt, r_err_cnt_next;

    // The shift register rotates instead of shifting out, so after CHAIN_LEN
    // steps it holds the original pattern again and the verify pass simply
    // keeps rotating.
    logic [CHAIN_LEN-1:0] w_shift_rot;
    logic                 w_last_bit;

    assign w_shift_rot = {r_shift[CHAIN_LEN-2:0], r_shift[CHAIN_LEN-1]};
    assign w_last_bit  = (r_bit_cnt == LAST_BIT);

    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_verify  <= 1'b0;
            r_se      <= 1'b0;
            r_si      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= r_state_next;
            r_shift   <= r_shift_next;
            r_bit_cnt <= r_bit_cnt_next;
            r_verify  <= r_verify_next;
            r_se      <= r_se_next;
            r_si      <= r_si_next;
            r_busy    <= r_busy_next;
            r_done    <= r_done_next;
            r_error   <= r_error_next;
            r_err_cnt <= r_err_cnt_next;
        end
    end

    always_comb begin
        r_state_next   = r_state;
        r_shift_next   = r_shift;
        r_bit_cnt_next = r_bit_cnt;
        r_verify_next  = r_verify;
        r_se_next      = 1'b0;
        r_si_next      = 1'b0;
        r_busy_next    = 1'b0;
        r_done_next    = 1'b0;
        r_error_next   = r_error;
        r_err_cnt_next = r_err_cnt;

        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    // si_id is registered, so the first bit goes straight to
                    // r_si and the shift register is loaded already rotated
                    // by one so its MSB is the second bit.
                    r_shift_next   = {cfg_ids[CHAIN_LEN-2:0], cfg_ids[CHAIN_LEN-1]};
                    r_si_next      = cfg_ids[CHAIN_LEN-1];
                    r_verify_next  = verify_en;
                    r_bit_cnt_next = '0;
                    r_error_next   = 1'b0;
                    r_err_cnt_next = '0;
                    r_se_next      = 1'b1;
                    r_busy_next    = 1'b1;
                    r_state_next   = LOAD;
                end
            end

            LOAD: begin
                r_shift_next   = w_shift_rot;
                r_bit_cnt_next = r_bit_cnt + 1'b1;
                if (w_last_bit && !r_verify) begin
                    r_bit_cnt_next = '0;
                    r_done_next    = 1'b1;
                    r_state_next   = DONE;
                end else begin
                    if (w_last_bit) begin
                        r_bit_cnt_next = '0;
                        r_state_next   = VERIFY;
                    end
                    r_se_next   = 1'b1;
                    r_si_next   = r_shift[CHAIN_LEN-1];
                    r_busy_next = 1'b1;
                end
            end

            VERIFY: begin
                // The chain is exactly CHAIN_LEN deep, so the bit emerging on
                // so_id now is the one being driven on si_id now: the
                // registered si_id is the expected readback bit.
                if (so_id != r_si) begin
                    r_error_next = 1'b1;
                    if (r_err_cnt != ERR_MAX) begin
                        r_err_cnt_next = r_err_cnt + 1'b1;
                    end
                end
                r_shift_next   = w_shift_rot;
                r_bit_cnt_next = r_bit_cnt + 1'b1;
                if (w_last_bit) begin
                    r_bit_cnt_next = '0;
                    r_done_next    = 1'b1;
                    r_state_next   = DONE;
                end else begin
                    r_se_next   = 1'b1;
                    r_si_next   = r_shift[CHAIN_LEN-1];
                    r_busy_next = 1'b1;
                end
            end

            DONE: begin
                r_state_next = IDLE;
            end

            default: begin
                r_state_next = IDLE;
            end
        endcase

        // Abort drops everything without a done pulse; the mismatch result
        // gathered so far is kept, and this cycle's compare is discarded.
        if (abort && (r_state != IDLE)) begin
            r_state_next   = IDLE;
            r_bit_cnt_next = '0;
            r_se_next      = 1'b0;
            r_si_next      = 1'b0;
            r_busy_next    = 1'b0;
            r_done_next    = 1'b0;
            r_error_next   = r_error;
            r_err_cnt_next = r_err_cnt;
        end
    end

    assign se_id    = r_se;
    assign si_id    = r_si;
    assign busy     = r_busy;
    assign gin_hold = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign err_cnt  = r_err_cnt;

endmodule
